// File: rtl/mult4_seq_mac_ctrl.sv
// mult4_seq_mac_ctrl: sequential OPW x OPW multiply-accumulate
// built from one shared 4x4 nibble multiplier.
module mult4_seq_mac_ctrl #(
  parameter int OPW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  input  logic             acc_en,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OPW-1:0] prod,
  output logic             busy
);

  localparam int ND    = OPW / 4;
  localparam int NSTEP = ND * ND;
  localparam int AW    = 2 * OPW;
  localparam int SW    = $clog2(NSTEP + 1);
  localparam int IW    = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [OPW-1:0] a_q;
  logic [OPW-1:0] b_q;
  logic [AW-1:0]  acc_q;
  logic [SW-1:0]  step_q;
  logic [IW-1:0]  ia_q;
  logic [IW-1:0]  ib_q;

  logic           accept;
  logic           last;
  logic [OPW-1:0] a_sh;
  logic [OPW-1:0] b_sh;
  logic [7:0]     pp;
  logic [IW:0]    nib_sum;
  logic [AW-1:0]  pp_sh;

  assign accept = in_valid & in_ready;
  assign last   = (step_q == SW'(NSTEP - 1));
  assign prod   = acc_q;

  // select the current nibble pair, multiply, align to its weight
  always_comb begin
    a_sh    = a_q >> {ia_q, 2'b00};
    b_sh    = b_q >> {ib_q, 2'b00};
    pp      = {4'h0, a_sh[3:0]} * {4'h0, b_sh[3:0]};
    nib_sum = {1'b0, ia_q} + {1'b0, ib_q};
    pp_sh   = AW'(pp) << {nib_sum, 2'b00};
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // operand latch, step counters and shift-add accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      step_q <= '0;
      ia_q   <= '0;
      ib_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr) acc_q <= '0;
          if (accept) begin
            a_q    <= a;
            b_q    <= b;
            step_q <= '0;
            ia_q   <= '0;
            ib_q   <= '0;
            if (!acc_en) acc_q <= '0;
          end
        end
        MUL: begin
          acc_q  <= acc_q + pp_sh;
          step_q <= step_q + SW'(1);
          if (ia_q == IW'(ND - 1)) begin
            ia_q <= '0;
            ib_q <= ib_q + IW'(1);
          end else begin
            ia_q <= ia_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult4_seq_mac_ctrl.sv
// tb_mult4_seq_mac_ctrl: scoreboard bench for the sequential MAC,
// directed cases on OPW=8 and random traffic on OPW=8 and OPW=12.
module tb_mult4_seq_mac_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid8 = 0, in_ready8, acc_en8 = 0, clr8 = 0;
  logic        out_valid8, out_ready8 = 1, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] prod8;

  logic        in_valid12 = 0, in_ready12, acc_en12 = 0, clr12 = 0;
  logic        out_valid12, out_ready12 = 1, busy12;
  logic [11:0] a12 = 0, b12 = 0;
  logic [23:0] prod12;

  mult4_seq_mac_ctrl #(.OPW(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .acc_en(acc_en8), .clr(clr8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .prod(prod8), .busy(busy8)
  );

  mult4_seq_mac_ctrl #(.OPW(12)) u12 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid12), .in_ready(in_ready12),
    .a(a12), .b(b12), .acc_en(acc_en12), .clr(clr12),
    .out_valid(out_valid12), .out_ready(out_ready12),
    .prod(prod12), .busy(busy12)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model + scoreboard, OPW=8
  logic [15:0] q8[$];
  logic [15:0] m8 = 0;
  logic [15:0] hval8 = 0;
  logic        pov8 = 0, hv8 = 0;
  int          cyc8 = 0, tacc8 = 0, nacc8 = 0;

  always @(negedge clk) begin
    cyc8++;
    if (!rst_n) begin
      q8.delete();
      m8 = 0; pov8 = 0; hv8 = 0;
    end else begin
      chk("rdy_busy8", in_ready8, !busy8);
      if (out_valid8 && !pov8)
        chk("latency8", cyc8 - tacc8, 5);
      if (hv8 && out_valid8)
        chk("hold8", prod8, hval8);
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb8: unexpected result %0h", prod8);
        end else begin
          chk("prod8", prod8, q8.pop_front());
        end
      end
      hv8   = out_valid8 && !out_ready8;
      hval8 = prod8;
      pov8  = out_valid8;
      if (in_ready8 && clr8) m8 = 0;
      if (in_ready8 && in_valid8) begin
        m8 = (acc_en8 ? m8 : 16'h0) + {8'h0, a8} * {8'h0, b8};
        q8.push_back(m8);
        tacc8 = cyc8;
        nacc8++;
      end
    end
  end

  // reference model + scoreboard, OPW=12 (NSTEP=9)
  logic [23:0] q12[$];
  logic [23:0] m12 = 0;
  logic [23:0] hval12 = 0;
  logic        pov12 = 0, hv12 = 0;
  int          cyc12 = 0, tacc12 = 0, nacc12 = 0;

  always @(negedge clk) begin
    cyc12++;
    if (!rst_n) begin
      q12.delete();
      m12 = 0; pov12 = 0; hv12 = 0;
    end else begin
      chk("rdy_busy12", in_ready12, !busy12);
      if (out_valid12 && !pov12)
        chk("latency12", cyc12 - tacc12, 10);
      if (hv12 && out_valid12)
        chk("hold12", prod12, hval12);
      if (out_valid12 && out_ready12) begin
        if (q12.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb12: unexpected result %0h", prod12);
        end else begin
          chk("prod12", prod12, q12.pop_front());
        end
      end
      hv12   = out_valid12 && !out_ready12;
      hval12 = prod12;
      pov12  = out_valid12;
      if (in_ready12 && clr12) m12 = 0;
      if (in_ready12 && in_valid12) begin
        m12 = (acc_en12 ? m12 : 24'h0) + {12'h0, a12} * {12'h0, b12};
        q12.push_back(m12);
        tacc12 = cyc12;
        nacc12++;
      end
    end
  end

  task automatic send8(input logic [7:0] av, input logic [7:0] bv,
                       input logic ae, input logic cl);
    int n = 0;
    @(posedge clk); #1;
    a8 = av; b8 = bv; acc_en8 = ae; clr8 = cl; in_valid8 = 1'b1;
    while (!in_ready8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept8", in_ready8, 1'b1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; clr8 = 1'b0;
  endtask

  task automatic get8(input string nm, input logic [15:0] exp);
    int n = 0;
    @(negedge clk);
    while (!out_valid8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, out_valid8, 1'b1);
    chk(nm, prod8, exp);
  endtask

  task automatic drive8(input int target);
    int cy = 0;
    while (nacc8 < target && cy < 30000) begin
      @(posedge clk); #1;
      in_valid8  = ($urandom_range(0, 3) != 0);
      a8         = 8'($urandom);
      b8         = 8'($urandom);
      acc_en8    = 1'($urandom_range(0, 1));
      clr8       = ($urandom_range(0, 7) == 0);
      out_ready8 = ($urandom_range(0, 3) != 0);
      cy++;
    end
    in_valid8 = 1'b0; clr8 = 1'b0; out_ready8 = 1'b1;
  endtask

  task automatic drive12(input int target);
    int cy = 0;
    while (nacc12 < target && cy < 30000) begin
      @(posedge clk); #1;
      in_valid12  = ($urandom_range(0, 3) != 0);
      a12         = 12'($urandom);
      b12         = 12'($urandom);
      acc_en12    = 1'($urandom_range(0, 1));
      clr12       = ($urandom_range(0, 7) == 0);
      out_ready12 = ($urandom_range(0, 3) != 0);
      cy++;
    end
    in_valid12 = 1'b0; clr12 = 1'b0; out_ready12 = 1'b1;
  endtask

  initial begin
    int t8, t12, seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready8, 1'b1);
    chk("rst_out_valid", out_valid8, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_prod", prod8, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send8(8'hFF, 8'hFF, 1'b0, 1'b0);
    get8("ff_x_ff", 16'hFE01);
    send8(8'hFF, 8'hFF, 1'b1, 1'b0);
    get8("ff_x_ff_acc", 16'hFC02);

    @(posedge clk); #1 clr8 = 1'b1;
    @(posedge clk); #1 clr8 = 1'b0;
    send8(8'h03, 8'h05, 1'b1, 1'b0);
    get8("clr_then_acc", 16'h000F);

    send8(8'h02, 8'h03, 1'b1, 1'b1);
    get8("clr_wins", 16'h0006);
    send8(8'h01, 8'h01, 1'b1, 1'b0);
    get8("acc_after_clr", 16'h0007);

    send8(8'h00, 8'hA5, 1'b0, 1'b0);
    get8("zero", 16'h0000);
    send8(8'h10, 8'h01, 1'b0, 1'b0);
    get8("nib_shift", 16'h0010);
    send8(8'h80, 8'h80, 1'b0, 1'b0);
    get8("top_bits", 16'h4000);

    @(posedge clk); #1 out_ready8 = 1'b0;
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    get8("bp_first", 16'h03A8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid8, 1'b1);
      chk("bp_prod", prod8, 16'h03A8);
      chk("bp_in_ready", in_ready8, 1'b0);
      chk("bp_busy", busy8, 1'b1);
    end
    @(posedge clk); #1 out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_rdy", in_ready8, 1'b1);
    chk("bp_release_ov", out_valid8, 1'b0);

    send8(8'hFF, 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready8, 1'b1);
    chk("abort_out_valid", out_valid8, 1'b0);
    chk("abort_prod", prod8, 16'h0);
    chk("abort_busy", busy8, 1'b0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid8) seen++;
    end
    chk("abort_no_result", seen, 0);

    t8  = nacc8 + 1000;
    t12 = nacc12 + 1000;
    fork
      drive8(t8);
      drive12(t12);
    join
    chk("rand_count8", nacc8 >= t8, 1'b1);
    chk("rand_count12", nacc12 >= t12, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("drain8", q8.size(), 0);
    chk("drain12", q12.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
